fpga_regs_readback: RTL and testbench

Return-path responder for the FPGA control-register channels 11..20. Every master write on one of these channels produces a one-byte acknowledge message: the value of the addressed register one cycle after the write. The message is queued per channel and served to the master through the per-channel message/read-request interface (`have_msg_bus` / `rdreq_bus` / `slave_data_bus` / `len_bus`). It sits beside the control-register block, taking that block's register outputs as inputs.

---
 rtl/fpga_regs_pkg.sv | 24 ++
 rtl/msg_fifo2.sv | 95 +++++++++
 rtl/fpga_regs_readback.sv | 105 ++++++++++
 tb/tb_fpga_regs_readback.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_regs_pkg
// Description : Shared constants and bus-slicing helper for the control
//               register readback path (channels 11..20).
// Contents    : CH_FIRST / CH_LAST  - served channel range
//               MSG_W               - acknowledge message width in bits
//               msg_lo()            - low bit of channel byte in packed buses
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_regs_pkg;

  localparam int CH_FIRST = 11;
  localparam int CH_LAST  = 20;
  localparam int MSG_W    = 8;

  // Packed per-channel buses place channel i at [MSG_W*i +: MSG_W], so the
  // bus declared range starts at MSG_W*CH_FIRST rather than 0.
  function automatic int msg_lo(input int ch);
    return ch * MSG_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : msg_fifo2
// Description : Two-entry show-ahead message FIFO with sticky overflow flag.
// Ports       : clk, n_rst     - clock, synchronous active-low reset
//               i_push, i_data - enqueue one byte
//               i_pop          - dequeue head byte (ignored when empty)
//               o_data         - head byte, combinational from storage
//               o_count        - bytes held (0..2)
//               o_overflow     - set when a push found no room; reset-only clear
// Revision    : 1.0 - initial release
// ============================================================================
module msg_fifo2
  import fpga_regs_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  logic [MSG_W-1:0] i_data,
  input  logic             i_pop,
  output logic [MSG_W-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_overflow
);

  localparam logic [1:0] C_FULL = 2'(DEPTH);

  logic [MSG_W-1:0] mem_q [2];
  logic [MSG_W-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             w_do_pop;
  logic             w_room;
  logic             w_do_push;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    // A pop on an empty FIFO is dropped; a pop on a full FIFO frees the slot
    // the same-cycle push lands in, so that case is not an overflow.
    w_do_pop  = i_pop && (count_q != 2'd0);
    w_room    = (count_q != C_FULL) || w_do_pop;
    w_do_push = i_push && w_room;

    if (w_do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (i_push && !w_room) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_data     = mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: rtl/fpga_regs_readback.sv
`default_nettype none
// ============================================================================
// Module      : fpga_regs_readback
// Description : Acknowledge responder for control-register channels 11..20.
//               Each master write queues one byte holding the addressed
//               register value as seen one cycle after the write.
// Ports       : clk, n_rst        - clock, synchronous active-low reset
//               valid_bus         - per-channel master write strobe
//               rdreq_bus         - per-channel master pop request
//               have_msg_bus      - per-channel "byte queued" flag
//               slave_data_bus    - per-channel head byte (byte i at [8i+7:8i])
//               len_bus           - per-channel queued count (byte i)
//               overflow_bus      - per-channel sticky dropped-ack flag
//               a .. off_vdigital_fpga - register values from the reg block
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_regs_readback
  import fpga_regs_pkg::*;
#(
  parameter int CH_FIRST = fpga_regs_pkg::CH_FIRST,
  parameter int CH_LAST  = fpga_regs_pkg::CH_LAST,
  parameter int DEPTH    = 2
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic [CH_LAST:CH_FIRST]                     valid_bus,
  input  logic [CH_LAST:CH_FIRST]                     rdreq_bus,
  output logic [CH_LAST:CH_FIRST]                     have_msg_bus,
  output logic [MSG_W*CH_LAST+MSG_W-1:MSG_W*CH_FIRST] slave_data_bus,
  output logic [MSG_W*CH_LAST+MSG_W-1:MSG_W*CH_FIRST] len_bus,
  output logic [CH_LAST:CH_FIRST]                     overflow_bus,
  input  logic [3:0]                                  a,
  input  logic                                        load_pr_3v7,
  input  logic                                        load_pdr,
  input  logic                                        dac_gain,
  input  logic                                        dac_switch_out_fpga,
  input  logic                                        dac_ena_out_fpga,
  input  logic                                        off_pr_digital_fpga,
  input  logic                                        functional,
  input  logic                                        video_in_select,
  input  logic                                        off_vcore_fpga,
  input  logic                                        off_vdigital_fpga
);

  logic [CH_LAST:CH_FIRST] ack_pend_q, ack_pend_d;
  logic [MSG_W-1:0]        w_snap [CH_LAST:CH_FIRST];
  logic [7:0]              w_flag_bits;

  // Single-bit registers served by channels CH_FIRST+2 upward, bit k for
  // channel CH_FIRST+2+k.
  assign w_flag_bits = {off_vdigital_fpga, off_vcore_fpga, video_in_select,
                        functional, off_pr_digital_fpga, dac_ena_out_fpga,
                        dac_switch_out_fpga, dac_gain};

  always_comb begin
    for (int c = CH_FIRST; c <= CH_LAST; c++) begin
      w_snap[c] = '0;
    end
    w_snap[CH_FIRST]   = {4'b0, a};
    w_snap[CH_FIRST+1] = {6'b0, load_pr_3v7, load_pdr};
    for (int k = 0; k < 8; k++) begin
      w_snap[CH_FIRST+2+k] = {7'b0, w_flag_bits[k]};
    end
  end

  // One-cycle delay so the snapshot is taken after the register block has
  // applied the write.
  always_comb begin
    ack_pend_d = valid_bus;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ack_pend_q <= '0;
    end else begin
      ack_pend_q <= ack_pend_d;
    end
  end

  for (genvar c = CH_FIRST; c <= CH_LAST; c++) begin : g_ch
    localparam int LO = msg_lo(c);

    logic [1:0]       w_count;
    logic [MSG_W-1:0] w_data;

    msg_fifo2 #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_push     (ack_pend_q[c]),
      .i_data     (w_snap[c]),
      .i_pop      (rdreq_bus[c]),
      .o_data     (w_data),
      .o_count    (w_count),
      .o_overflow (overflow_bus[c])
    );

    assign have_msg_bus[c]             = (w_count != 2'd0);
    assign slave_data_bus[LO +: MSG_W] = w_data;
    assign len_bus[LO +: MSG_W]        = {{(MSG_W-2){1'b0}}, w_count};
  end

endmodule
`default_nettype wire

// File: tb/tb_fpga_regs_readback.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpga_regs_readback
// Description : Directed self-checking bench for fpga_regs_readback, with a
//               queue-based reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_regs_readback;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [20:11]  valid_bus;
  logic [20:11]  rdreq_bus;
  logic [20:11]  have_msg_bus;
  logic [167:88] slave_data_bus;
  logic [167:88] len_bus;
  logic [20:11]  overflow_bus;
  logic [3:0]    a;
  logic          load_pr_3v7, load_pdr, dac_gain, dac_switch_out_fpga;
  logic          dac_ena_out_fpga, off_pr_digital_fpga, functional;
  logic          video_in_select, off_vcore_fpga, off_vdigital_fpga;

  int n_checks = 0;
  int n_fail   = 0;

  fpga_regs_readback dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .valid_bus           (valid_bus),
    .rdreq_bus           (rdreq_bus),
    .have_msg_bus        (have_msg_bus),
    .slave_data_bus      (slave_data_bus),
    .len_bus             (len_bus),
    .overflow_bus        (overflow_bus),
    .a                   (a),
    .load_pr_3v7         (load_pr_3v7),
    .load_pdr            (load_pdr),
    .dac_gain            (dac_gain),
    .dac_switch_out_fpga (dac_switch_out_fpga),
    .dac_ena_out_fpga    (dac_ena_out_fpga),
    .off_pr_digital_fpga (off_pr_digital_fpga),
    .functional          (functional),
    .video_in_select     (video_in_select),
    .off_vcore_fpga      (off_vcore_fpga),
    .off_vdigital_fpga   (off_vdigital_fpga)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel, capped at two bytes.
  logic [7:0]   mq [0:9][$];
  logic [20:11] m_pend;
  logic [20:11] m_ovf;

  function automatic logic [7:0] snap(input int c);
    case (c)
      11:      return {4'b0, a};
      12:      return {6'b0, load_pr_3v7, load_pdr};
      13:      return {7'b0, dac_gain};
      14:      return {7'b0, dac_switch_out_fpga};
      15:      return {7'b0, dac_ena_out_fpga};
      16:      return {7'b0, off_pr_digital_fpga};
      17:      return {7'b0, functional};
      18:      return {7'b0, video_in_select};
      19:      return {7'b0, off_vcore_fpga};
      20:      return {7'b0, off_vdigital_fpga};
      default: return 8'h00;
    endcase
  endfunction

  task automatic set_reg(input int c, input logic [7:0] v);
    case (c)
      11: a = v[3:0];
      12: begin load_pr_3v7 = v[1]; load_pdr = v[0]; end
      13: dac_gain            = v[0];
      14: dac_switch_out_fpga = v[0];
      15: dac_ena_out_fpga    = v[0];
      16: off_pr_digital_fpga = v[0];
      17: functional          = v[0];
      18: video_in_select     = v[0];
      19: off_vcore_fpga      = v[0];
      20: off_vdigital_fpga   = v[0];
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compare();
    logic [167:88] e_len, e_data, mask;
    logic [20:11]  e_have;
    e_len  = '0;
    e_data = '0;
    mask   = '0;
    e_have = '0;
    for (int i = 0; i < 10; i++) begin
      e_have[i+11]         = (mq[i].size() != 0);
      e_len[8*(i+11) +: 8] = 8'(mq[i].size());
      if (mq[i].size() != 0) begin
        e_data[8*(i+11) +: 8] = mq[i][0];
        mask[8*(i+11) +: 8]   = 8'hFF;
      end
    end
    chk("have_msg", 80'(have_msg_bus), 80'(e_have));
    chk("len", len_bus, e_len);
    chk("slave_data", slave_data_bus & mask, e_data);
    chk("overflow", 80'(overflow_bus), 80'(m_ovf));
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // check the DUT shortly after the edge.
  task automatic tick();
    @(posedge clk);
    if (!n_rst) begin
      for (int i = 0; i < 10; i++) mq[i].delete();
      m_pend = '0;
      m_ovf  = '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (rdreq_bus[i+11] && mq[i].size() != 0) mq[i].delete(0);
        if (m_pend[i+11]) begin
          if (mq[i].size() < 2) mq[i].push_back(snap(i+11));
          else m_ovf[i+11] = 1'b1;
        end
      end
      m_pend = valid_bus;
    end
    #1;
    compare();
  endtask

  initial begin
    n_rst = 1'b0; valid_bus = '0; rdreq_bus = '0;
    a = 4'h0; load_pr_3v7 = 0; load_pdr = 0; dac_gain = 0;
    dac_switch_out_fpga = 0; dac_ena_out_fpga = 0; off_pr_digital_fpga = 0;
    functional = 0; video_in_select = 0; off_vcore_fpga = 0; off_vdigital_fpga = 0;
    m_pend = '0; m_ovf = '0;
    tick(); tick();
    n_rst = 1'b1;
    tick();
    chk("rst_have", 80'(have_msg_bus), 80'h0);
    chk("rst_len", len_bus, 80'h0);
    chk("rst_data", slave_data_bus, 80'h0);

    // ch11 single write and pop
    valid_bus[11] = 1; tick();
    valid_bus[11] = 0; set_reg(11, 8'h0A); tick();
    chk("t1_have11", 80'(have_msg_bus[11]), 80'h1);
    chk("t1_len11", 80'(len_bus[95:88]), 80'h01);
    chk("t1_data11", 80'(slave_data_bus[95:88]), 80'h0A);
    rdreq_bus[11] = 1; tick();
    rdreq_bus[11] = 0;
    chk("t1_pop_len11", 80'(len_bus[95:88]), 80'h00);

    // ch12 back-to-back, popped in order
    valid_bus[12] = 1; tick();
    set_reg(12, 8'h02); tick();
    set_reg(12, 8'h01); valid_bus[12] = 0; tick();
    chk("t2_len12", 80'(len_bus[103:96]), 80'h02);
    chk("t2_head12a", 80'(slave_data_bus[103:96]), 80'h02);
    rdreq_bus[12] = 1; tick();
    chk("t2_head12b", 80'(slave_data_bus[103:96]), 80'h01);
    tick();
    rdreq_bus[12] = 0;
    chk("t2_empty12", 80'(len_bus[103:96]), 80'h00);

    // ch15 overflow on third write
    valid_bus[15] = 1; tick();
    set_reg(15, 8'h01); tick();
    set_reg(15, 8'h00); tick();
    set_reg(15, 8'h01); valid_bus[15] = 0; tick();
    chk("t3_len15", 80'(len_bus[127:120]), 80'h02);
    chk("t3_head15", 80'(slave_data_bus[127:120]), 80'h01);
    chk("t3_ovf", 80'(overflow_bus), 80'h010);
    rdreq_bus[15] = 1; tick();
    chk("t3_second15", 80'(slave_data_bus[127:120]), 80'h00);
    tick();
    rdreq_bus[15] = 0;

    // ch16 full with simultaneous push and pop
    valid_bus[16] = 1; tick();
    set_reg(16, 8'h01); tick();
    set_reg(16, 8'h00); tick();
    set_reg(16, 8'h01); valid_bus[16] = 0; rdreq_bus[16] = 1; tick();
    rdreq_bus[16] = 0;
    chk("t4_len16", 80'(len_bus[135:128]), 80'h02);
    chk("t4_head16", 80'(slave_data_bus[135:128]), 80'h00);
    chk("t4_ovf16", 80'(overflow_bus[16]), 80'h0);
    rdreq_bus[16] = 1; tick(); tick(); tick();
    rdreq_bus[16] = 0;

    // ch13 + ch20 together; rdreq on empty ch14
    valid_bus[13] = 1; valid_bus[20] = 1; tick();
    valid_bus = '0; set_reg(13, 8'h01); set_reg(20, 8'h01); tick();
    chk("t5_have", 80'(have_msg_bus), 80'h204);
    rdreq_bus[14] = 1; tick();
    rdreq_bus[14] = 0;
    chk("t5_have_after14", 80'(have_msg_bus), 80'h204);
    rdreq_bus = '1; tick();
    rdreq_bus = '0;

    // reset while ch19 full and acks pending on ch19 and ch17
    valid_bus[19] = 1; tick();
    set_reg(19, 8'h01); tick();
    set_reg(19, 8'h00); valid_bus[17] = 1; set_reg(17, 8'h01); tick();
    chk("t6_len19", 80'(len_bus[159:152]), 80'h02);
    valid_bus = '0; n_rst = 1'b0; tick();
    n_rst = 1'b1; tick(); tick();
    chk("t6_have", 80'(have_msg_bus), 80'h0);
    chk("t6_len", len_bus, 80'h0);
    chk("t6_data", slave_data_bus, 80'h0);
    chk("t6_ovf", 80'(overflow_bus), 80'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
